// File: rtl/rs_entry_alloc_ctrl.sv
// Reservation-station entry allocator: owns the busy vector, hands out the two
// lowest free entries to dispatch each cycle and retires entries released by issue.
module rs_entry_alloc_ctrl #(
   parameter int ENT_NUM = 8,
   parameter int ENT_SEL = 3,
   parameter int REQ_W   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_flush,
   input  logic [REQ_W-1:0]   i_req_num,
   input  logic               i_dp_stall,
   output logic               o_allocable,
   output logic               o_alloc_vld_1,
   output logic               o_alloc_vld_2,
   output logic [ENT_SEL-1:0] o_alloc_idx_1,
   output logic [ENT_SEL-1:0] o_alloc_idx_2,
   input  logic               i_rel_vld_1,
   input  logic [ENT_SEL-1:0] i_rel_idx_1,
   input  logic               i_rel_vld_2,
   input  logic [ENT_SEL-1:0] i_rel_idx_2,
   output logic [ENT_NUM-1:0] o_busy_vec,
   output logic [ENT_SEL:0]   o_used_cnt,
   output logic               o_full,
   output logic               o_empty,
   output logic               o_err_free
);

   localparam int CW = ENT_SEL + 1;

   logic [ENT_NUM-1:0] busy_vec;
   logic [ENT_NUM-1:0] busy_next;
   logic [ENT_NUM-1:0] free_vec;
   logic [ENT_NUM-1:0] free_rest;
   logic [ENT_NUM-1:0] alloc_mask;
   logic [ENT_NUM-1:0] rel_mask;
   logic [CW-1:0]      used_cnt;
   logic [CW-1:0]      used_next;
   logic [CW-1:0]      alloc_cnt;
   logic [CW-1:0]      rel_cnt;
   logic [REQ_W:0]     avail_cnt;
   logic               err_free;
   logic               err_next;
   logic               rel_err;
   logic               vld_1;
   logic               vld_2;
   logic [ENT_SEL-1:0] idx_1;
   logic [ENT_SEL-1:0] idx_2;
   logic               commit;

   assign free_vec = ~busy_vec;

   // Descending scan so the lowest free index is the last one written.
   always_comb begin
      vld_1 = 1'b0;
      idx_1 = '0;
      for (int i = ENT_NUM - 1; i >= 0; i--) begin
         if (free_vec[i]) begin
            vld_1 = 1'b1;
            idx_1 = ENT_SEL'(i);
         end
      end
   end

   assign free_rest = free_vec & ~(ENT_NUM'(vld_1) << idx_1);

   always_comb begin
      vld_2 = 1'b0;
      idx_2 = '0;
      for (int i = ENT_NUM - 1; i >= 0; i--) begin
         if (free_rest[i]) begin
            vld_2 = 1'b1;
            idx_2 = ENT_SEL'(i);
         end
      end
   end

   assign avail_cnt   = {{REQ_W{1'b0}}, vld_1} + {{REQ_W{1'b0}}, vld_2};
   assign o_allocable = ({1'b0, i_req_num} <= avail_cnt);
   assign commit      = o_allocable & ~i_dp_stall & ~i_flush;

   // Allocation is all-or-nothing: commit already guarantees enough free entries.
   always_comb begin
      alloc_mask = '0;
      alloc_cnt  = '0;
      if (commit && (i_req_num >= REQ_W'(1))) begin
         alloc_mask[idx_1] = 1'b1;
         alloc_cnt         = CW'(1);
      end
      if (commit && (i_req_num == REQ_W'(2))) begin
         alloc_mask[idx_2] = 1'b1;
         alloc_cnt         = CW'(2);
      end
   end

   // Two ports naming the same busy entry collapse into one bit of the mask.
   always_comb begin
      rel_mask = '0;
      rel_err  = 1'b0;
      if (i_rel_vld_1) begin
         if (busy_vec[i_rel_idx_1]) rel_mask[i_rel_idx_1] = 1'b1;
         else                       rel_err = 1'b1;
      end
      if (i_rel_vld_2) begin
         if (busy_vec[i_rel_idx_2]) rel_mask[i_rel_idx_2] = 1'b1;
         else                       rel_err = 1'b1;
      end
   end

   always_comb begin
      rel_cnt = '0;
      for (int i = 0; i < ENT_NUM; i++) begin
         rel_cnt = rel_cnt + CW'(rel_mask[i]);
      end
   end

   // Flush wipes the station and ignores this cycle's releases entirely.
   always_comb begin
      busy_next = (busy_vec | alloc_mask) & ~rel_mask;
      used_next = used_cnt + alloc_cnt - rel_cnt;
      err_next  = err_free | rel_err;
      if (i_flush) begin
         busy_next = '0;
         used_next = '0;
         err_next  = err_free;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_vec <= '0;
         used_cnt <= '0;
         err_free <= 1'b0;
      end else begin
         busy_vec <= busy_next;
         used_cnt <= used_next;
         err_free <= err_next;
      end
   end

   assign o_alloc_vld_1 = vld_1;
   assign o_alloc_vld_2 = vld_2;
   assign o_alloc_idx_1 = idx_1;
   assign o_alloc_idx_2 = idx_2;
   assign o_busy_vec    = busy_vec;
   assign o_used_cnt    = used_cnt;
   assign o_full        = (used_cnt == CW'(ENT_NUM));
   assign o_empty       = (used_cnt == '0);
   assign o_err_free    = err_free;

endmodule

// File: tb/tb_rs_entry_alloc_ctrl.sv
// Bench for rs_entry_alloc_ctrl: a free-list model checked every cycle, plus
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_rs_entry_alloc_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_flush;
   logic [1:0] i_req_num;
   logic       i_dp_stall;
   logic       o_allocable;
   logic       o_alloc_vld_1;
   logic       o_alloc_vld_2;
   logic [2:0] o_alloc_idx_1;
   logic [2:0] o_alloc_idx_2;
   logic       i_rel_vld_1;
   logic [2:0] i_rel_idx_1;
   logic       i_rel_vld_2;
   logic [2:0] i_rel_idx_2;
   logic [7:0] o_busy_vec;
   logic [3:0] o_used_cnt;
   logic       o_full;
   logic       o_empty;
   logic       o_err_free;

   int  compared = 0;
   int  mismatched = 0;
   bit  checkEn = 1'b0;
   bit [7:0] modelBusy = '0;
   bit       modelErr = 1'b0;

   rs_entry_alloc_ctrl #(.ENT_NUM(8), .ENT_SEL(3), .REQ_W(2)) dut (
      .clk(clk), .rst(rst), .i_flush(i_flush), .i_req_num(i_req_num),
      .i_dp_stall(i_dp_stall), .o_allocable(o_allocable),
      .o_alloc_vld_1(o_alloc_vld_1), .o_alloc_vld_2(o_alloc_vld_2),
      .o_alloc_idx_1(o_alloc_idx_1), .o_alloc_idx_2(o_alloc_idx_2),
      .i_rel_vld_1(i_rel_vld_1), .i_rel_idx_1(i_rel_idx_1),
      .i_rel_vld_2(i_rel_vld_2), .i_rel_idx_2(i_rel_idx_2),
      .o_busy_vec(o_busy_vec), .o_used_cnt(o_used_cnt), .o_full(o_full),
      .o_empty(o_empty), .o_err_free(o_err_free)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit fl, input int rq, input bit st,
                                input bit v1, input int i1, input bit v2, input int i2);
      i_flush     = fl;
      i_req_num   = 2'(rq);
      i_dp_stall  = st;
      i_rel_vld_1 = v1;
      i_rel_idx_1 = 3'(i1);
      i_rel_vld_2 = v2;
      i_rel_idx_2 = 3'(i2);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: free list is the ascending list of non-busy entries.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         modelBusy = '0;
         modelErr  = 1'b0;
      end else begin
         int freeList[$];
         int avail;
         bit [7:0] nb;
         freeList.delete();
         for (int i = 0; i < 8; i++) if (!modelBusy[i]) freeList.push_back(i);
         avail = (freeList.size() > 2) ? 2 : freeList.size();
         nb = modelBusy;
         if (i_flush) begin
            nb = '0;
         end else begin
            if ((int'(i_req_num) <= avail) && !i_dp_stall)
               for (int k = 0; k < int'(i_req_num); k++) nb[freeList[k]] = 1'b1;
            if (i_rel_vld_1) begin
               if (modelBusy[i_rel_idx_1]) nb[i_rel_idx_1] = 1'b0;
               else modelErr = 1'b1;
            end
            if (i_rel_vld_2) begin
               if (modelBusy[i_rel_idx_2]) nb[i_rel_idx_2] = 1'b0;
               else modelErr = 1'b1;
            end
         end
         modelBusy = nb;
      end
   end

   // Compare process: every falling edge, DUT outputs against the model.
   always @(negedge clk) begin
      if (checkEn) begin
         int freeList[$];
         int avail;
         int cnt;
         freeList.delete();
         for (int i = 0; i < 8; i++) if (!modelBusy[i]) freeList.push_back(i);
         avail = (freeList.size() > 2) ? 2 : freeList.size();
         cnt   = 8 - freeList.size();
         checkOutput("model_busy_vec", 32'(o_busy_vec), 32'(modelBusy));
         checkOutput("model_used_cnt", 32'(o_used_cnt), 32'(cnt));
         checkOutput("model_full", 32'(o_full), 32'(cnt == 8));
         checkOutput("model_empty", 32'(o_empty), 32'(cnt == 0));
         checkOutput("model_err_free", 32'(o_err_free), 32'(modelErr));
         checkOutput("model_vld_1", 32'(o_alloc_vld_1), 32'(freeList.size() >= 1));
         checkOutput("model_vld_2", 32'(o_alloc_vld_2), 32'(freeList.size() >= 2));
         checkOutput("model_idx_1", 32'(o_alloc_idx_1), (freeList.size() >= 1) ? 32'(freeList[0]) : 32'd0);
         checkOutput("model_idx_2", 32'(o_alloc_idx_2), (freeList.size() >= 2) ? 32'(freeList[1]) : 32'd0);
         checkOutput("model_allocable", 32'(o_allocable), 32'(int'(i_req_num) <= avail));
      end
   end

   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #2;
      checkEn = 1'b1;
      checkOutput("rst_busy", 32'(o_busy_vec), 32'h00);
      checkOutput("rst_used", 32'(o_used_cnt), 32'd0);
      checkOutput("rst_empty", 32'(o_empty), 32'd1);
      checkOutput("rst_full", 32'(o_full), 32'd0);
      checkOutput("rst_idx_pair", {o_alloc_vld_1, o_alloc_vld_2, o_alloc_idx_1, o_alloc_idx_2}, 32'b11_000_001);
      checkOutput("rst_allocable", 32'(o_allocable), 32'd1);
      checkOutput("rst_err", 32'(o_err_free), 32'd0);
      #3 rst = 1'b0;
      tick();

      // Fill the station two entries at a time.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 2, 0, 0, 0, 0, 0);
         #1;
         checkOutput($sformatf("fill_pair_%0d", k), {o_alloc_idx_1, o_alloc_idx_2}, 32'((2*k) * 8 + 2*k + 1));
         tick();
      end
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      #1;
      checkOutput("full_flag", 32'(o_full), 32'd1);
      checkOutput("full_busy", 32'(o_busy_vec), 32'hFF);
      checkOutput("full_used", 32'(o_used_cnt), 32'd8);
      checkOutput("full_allocable_req1", 32'(o_allocable), 32'd0);
      checkOutput("full_vld", {o_alloc_vld_1, o_alloc_vld_2}, 32'd0);

      // Release 3 and 6 together, then refill both.
      applyStimulus(0, 0, 0, 1, 3, 1, 6);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("rel2_busy", 32'(o_busy_vec), 32'hB7);
      checkOutput("rel2_used", 32'(o_used_cnt), 32'd6);
      checkOutput("rel2_idx_pair", {o_alloc_idx_1, o_alloc_idx_2}, 32'b011_110);
      applyStimulus(0, 2, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("refill_busy", 32'(o_busy_vec), 32'hFF);

      // Both ports naming the same busy entry free it once without error.
      applyStimulus(0, 0, 0, 1, 2, 1, 2);
      tick();
      applyStimulus(0, 0, 0, 1, 7, 0, 0);
      #1;
      checkOutput("dup_rel_busy", 32'(o_busy_vec), 32'hFB);
      checkOutput("dup_rel_used", 32'(o_used_cnt), 32'd7);
      checkOutput("dup_rel_err", 32'(o_err_free), 32'd0);
      tick();
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      tick();

      // One free entry: a request for two is refused while a release lands.
      applyStimulus(0, 2, 0, 1, 0, 0, 0);
      #1;
      checkOutput("one_free_busy", 32'(o_busy_vec), 32'h7F);
      checkOutput("one_free_allocable", 32'(o_allocable), 32'd0);
      checkOutput("one_free_vld", {o_alloc_vld_1, o_alloc_vld_2, o_alloc_idx_1}, 32'b10_111);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("no_bypass_busy", 32'(o_busy_vec), 32'h7E);
      checkOutput("two_free_pair", {o_alloc_vld_1, o_alloc_vld_2, o_alloc_idx_1, o_alloc_idx_2}, 32'b11_000_111);

      // Stall holds the allocation off until it drops.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 2, 1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput($sformatf("stall_busy_%0d", k), 32'(o_busy_vec), 32'h00);
      end
      applyStimulus(0, 2, 0, 0, 0, 0, 0);
      #1;
      checkOutput("unstall_pair", {o_alloc_idx_1, o_alloc_idx_2}, 32'b000_001);
      tick();
      applyStimulus(0, 2, 0, 0, 0, 0, 0);
      #1;
      checkOutput("unstall_busy", 32'(o_busy_vec), 32'h03);
      tick();

      // Bad release sets a sticky error that survives a flush.
      applyStimulus(0, 0, 0, 1, 5, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("err_set", 32'(o_err_free), 32'd1);
      checkOutput("err_busy", 32'(o_busy_vec), 32'h0F);
      tick();
      checkOutput("err_sticky", 32'(o_err_free), 32'd1);
      applyStimulus(1, 2, 0, 1, 1, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("flush_busy", 32'(o_busy_vec), 32'h00);
      checkOutput("flush_used", 32'(o_used_cnt), 32'd0);
      checkOutput("flush_empty", 32'(o_empty), 32'd1);
      checkOutput("flush_err_kept", 32'(o_err_free), 32'd1);

      // Build 0x3C, then reset asynchronously in mid-cycle.
      applyStimulus(0, 2, 0, 0, 0, 0, 0);
      repeat (3) tick();
      applyStimulus(0, 0, 0, 1, 0, 1, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("pre_async_busy", 32'(o_busy_vec), 32'h3C);
      rst = 1'b1;
      #1;
      checkOutput("async_busy", 32'(o_busy_vec), 32'h00);
      checkOutput("async_used", 32'(o_used_cnt), 32'd0);
      checkOutput("async_err", 32'(o_err_free), 32'd0);
      checkOutput("async_empty", 32'(o_empty), 32'd1);
      #4 rst = 1'b0;
      applyStimulus(0, 2, 0, 0, 0, 0, 0);
      #1;
      checkOutput("post_rst_pair", {o_alloc_vld_1, o_alloc_vld_2, o_alloc_idx_1, o_alloc_idx_2}, 32'b11_000_001);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("post_rst_busy", 32'(o_busy_vec), 32'h03);

      // Randomized traffic; releases mostly target busy entries.
      for (int c = 0; c < 3000; c++) begin
         int busyList[$];
         int r1;
         int r2;
         busyList.delete();
         for (int i = 0; i < 8; i++) if (modelBusy[i]) busyList.push_back(i);
         r1 = (busyList.size() > 0 && ($urandom % 8) != 0) ? busyList[$urandom % busyList.size()] : int'($urandom % 8);
         r2 = (busyList.size() > 0 && ($urandom % 8) != 0) ? busyList[$urandom % busyList.size()] : int'($urandom % 8);
         rst = ((c % 600) == 300);
         applyStimulus(($urandom % 32) == 0, int'($urandom_range(0, 3)), ($urandom % 4) == 0,
                       ($urandom % 2) == 1, r1, ($urandom % 2) == 1, r2);
         tick();
      end
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
